// File: rtl/op_quiz_pkg.sv
// op_quiz_pkg: shared states, operator codes, segment patterns and puzzle helpers
// Segment patterns are abcdefg with a in bit 6, active-high.
package op_quiz_pkg;
  typedef enum logic [2:0] {S_IDLE, S_GEN, S_ASK, S_JUDGE, S_OVER} state_t;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [3:0] dig(input logic [3:0] x);
    return x >= 4'd10 ? x - 4'd10 : x;
  endfunction
  // Single-digit operator result, mod 10; operands are always 0..9
  function automatic logic [3:0] calc(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [7:0] p;
    s = {1'b0, a} + {1'b0, b};
    p = {4'd0, a} * {4'd0, b};
    return op == OP_ADD ? (s >= 5'd10 ? 4'(s - 5'd10) : s[3:0]) :
           op == OP_SUB ? (a >= b ? a - b : a + 4'd10 - b) :
           op == OP_MUL ? 4'(p % 8'd10) : 4'd0;
  endfunction
endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: 4-bit digit to abcdefg segments, 10..15 blank
// d: binary digit in; seg: active-high segments out
module seg7_dec
  import op_quiz_pkg::*;
(
  input  logic [3:0] d,
  output logic [6:0] seg
);
  always_comb begin
    case (d)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/op_quiz_engine.sv
// op_quiz_engine: LFSR operator quiz with round timeout, lives and BCD score
// clk/reset: clock, async active-high reset; start/switch: async buttons;
// tick: divider pulse; num1..3 + led1..3: puzzle digits and segments;
// score_*_led: score segments; lives, round_ok, round_fail, game_over: game status.
module op_quiz_engine
  import op_quiz_pkg::*;
#(
  parameter int          N_OPS       = 3,
  parameter int          LIVES       = 3,
  parameter int          ROUND_TICKS = 8,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N_OPS-1:0] switch,
  input  logic             tick,
  output logic [3:0]       num1,
  output logic [3:0]       num2,
  output logic [3:0]       num3,
  output logic [6:0]       led1,
  output logic [6:0]       led2,
  output logic [6:0]       led3,
  output logic [6:0]       score_tens_led,
  output logic [6:0]       score_ones_led,
  output logic [2:0]       lives,
  output logic             round_ok,
  output logic             round_fail,
  output logic             game_over
);
  state_t state, next;
  logic st_s1, st_s2, st_prev, start_edge;
  logic [N_OPS-1:0] sw_s1, sw_s2, sw_prev, sw_edge, ans, hit;
  logic [15:0] lfsr;
  logic [7:0] timer;
  logic [3:0] tens, ones, g1, g2, g3;
  logic [1:0] gop;
  logic [6:0] s1, s2, s3;
  logic correct, timeout, show;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {st_s1, st_s2, st_prev} <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
      sw_prev <= '0;
    end else begin
      st_s1 <= start;
      st_s2 <= st_s1;
      st_prev <= st_s2;
      sw_s1 <= switch;
      sw_s2 <= sw_s1;
      sw_prev <= sw_s2;
    end
  end
  assign start_edge = st_s2 & ~st_prev;
  assign sw_edge = sw_s2 & ~sw_prev;
  assign g1 = dig(lfsr[3:0]);
  assign g2 = dig(lfsr[7:4]);
  assign gop = 2'(int'(lfsr[9:8]) % N_OPS);
  assign g3 = calc(gop, g1, g2);
  // Any operator reproducing num3 is accepted, not just the generating one
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_OPS; i++) hit[i] = calc(2'(i), num1, num2) == num3;
  end
  assign correct = $onehot(ans) && |(ans & hit);
  assign timeout = tick && timer == 8'd1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      S_IDLE:  next = start_edge ? S_GEN : S_IDLE;
      S_GEN:   next = S_ASK;
      S_ASK:   next = (|sw_edge || timeout) ? S_JUDGE : S_ASK;
      S_JUDGE: next = (!correct && lives == 3'd1) ? S_OVER : S_GEN;
      S_OVER:  next = start_edge ? S_GEN : S_OVER;
      default: next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED;
      {num1, num2, num3} <= '0;
      timer <= '0;
      tens <= '0;
      ones <= '0;
      lives <= 3'(LIVES);
      ans <= '0;
      round_ok <= 1'b0;
      round_fail <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      round_ok <= state == S_JUDGE && correct;
      round_fail <= state == S_JUDGE && !correct;
      if ((state == S_IDLE || state == S_OVER) && start_edge) begin
        tens <= '0;
        ones <= '0;
        lives <= 3'(LIVES);
      end
      if (state == S_GEN) begin
        num1 <= g1;
        num2 <= g2;
        num3 <= g3;
        timer <= 8'(ROUND_TICKS);
      end
      // A timeout leaves ans at zero, which judges as wrong
      if (state == S_ASK) begin
        ans <= sw_edge;
        if (tick && timer != 8'd0) timer <= timer - 8'd1;
      end
      if (state == S_JUDGE && correct && !(tens == 4'd9 && ones == 4'd9)) begin
        ones <= ones == 4'd9 ? 4'd0 : ones + 4'd1;
        if (ones == 4'd9) tens <= tens + 4'd1;
      end
      if (state == S_JUDGE && !correct) lives <= lives - 3'd1;
    end
  end
  assign game_over = state == S_OVER;
  assign show = state == S_GEN || state == S_ASK || state == S_JUDGE;
  seg7_dec u_d1 (.d(num1), .seg(s1));
  seg7_dec u_d2 (.d(num2), .seg(s2));
  seg7_dec u_d3 (.d(num3), .seg(s3));
  seg7_dec u_st (.d(tens), .seg(score_tens_led));
  seg7_dec u_so (.d(ones), .seg(score_ones_led));
  assign led1 = show ? s1 : SEG_BLANK;
  assign led2 = show ? s2 : SEG_BLANK;
  assign led3 = show ? s3 : SEG_BLANK;
endmodule

// File: tb/tb_op_quiz_engine.sv
// tb_op_quiz_engine: scoreboard bench for op_quiz_engine
module tb_op_quiz_engine;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, tick = 1'b0;
  logic [2:0] switch = 3'b000;
  logic [3:0] num1, num2, num3;
  logic [6:0] led1, led2, led3, score_tens_led, score_ones_led;
  logic [2:0] lives;
  logic round_ok, round_fail, game_over;
  typedef struct {bit ok; int score; int lv; bit over; int cyc;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, exp_score = 0, exp_lives = 3, cop = 0;
  logic [15:0] m;
  logic [3:0] c1 = 0, c2 = 0, c3 = 0;

  op_quiz_engine #(.N_OPS(3), .LIVES(3), .ROUND_TICKS(2), .SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .start(start), .switch(switch), .tick(tick),
    .num1(num1), .num2(num2), .num3(num3), .led1(led1), .led2(led2), .led3(led3),
    .score_tens_led(score_tens_led), .score_ones_led(score_ones_led),
    .lives(lives), .round_ok(round_ok), .round_fail(round_fail), .game_over(game_over));

  always #5 clk = ~clk;

  function automatic logic [15:0] nxt(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction
  function automatic logic [3:0] dg(input logic [3:0] x);
    return x > 4'd9 ? x - 4'd10 : x;
  endfunction
  function automatic int res(input int op, input int a, input int b);
    return op == 0 ? (a + b) % 10 : op == 1 ? (a - b + 10) % 10 : (a * b) % 10;
  endfunction
  function automatic logic [11:0] puz(input logic [15:0] q);
    return {dg(q[3:0]), dg(q[7:4]), 4'(res(int'(q[9:8]) % 3, int'(dg(q[3:0])), int'(dg(q[7:4]))))};
  endfunction
  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  always @(posedge clk or posedge reset) m <= reset ? 16'hACE1 : nxt(m);
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic decode(input logic [15:0] q);
    {c1, c2, c3} = puz(q);
    cop = int'(q[9:8]) % 3;
  endtask

  task automatic check_digits;
    check("digits", {num1, num2, num3}, {c1, c2, c3});
    check("leds", {led1, led2, led3}, {seg(int'(c1)), seg(int'(c2)), seg(int'(c3))});
  endtask

  // Wait until the LFSR value latched 'ahead' edges from now yields the wanted add puzzle
  task automatic hunt(input int ahead, input logic [11:0] want);
    logic [15:0] q;
    bit found = 0;
    for (int n = 0; n < 30000 && !found; n++) begin
      q = m;
      for (int j = 0; j < ahead; j++) q = nxt(q);
      if (puz(q) == want && int'(q[9:8]) % 3 == 0) found = 1;
      else step;
    end
    if (!found) begin
      $display("FAIL hunt got=none exp=%0h", want);
      $fatal(1);
    end
  endtask

  task automatic start_game;
    exp_score = 0;
    exp_lives = 3;
    start = 1'b1;
    step;
    step;
    start = 1'b0;
    step;
    decode(m);
    step;
    check_digits;
    check("start_score", {score_tens_led, score_ones_led}, {seg(0), seg(0)});
    check("start_lives", lives, 3);
    check("start_over", game_over, 0);
  endtask

  task automatic round(input logic [2:0] mask, input bit to);
    exp_t e;
    int idx;
    bit ok;
    idx = mask[0] ? 0 : mask[1] ? 1 : 2;
    ok = !to && $onehot(mask) && res(idx, int'(c1), int'(c2)) == int'(c3);
    if (ok) exp_score = exp_score < 99 ? exp_score + 1 : 99;
    else exp_lives--;
    e = '{ok, exp_score, exp_lives, exp_lives == 0, cyc + 4};
    sb.push_back(e);
    if (to) begin
      tick = 1'b1; step; tick = 1'b0; step;
      tick = 1'b1; step; tick = 1'b0; step;
    end else begin
      switch = mask; step; step;
      switch = 3'b000; step; step;
    end
    if (e.over) begin
      check("over_flag", game_over, 1);
      check("over_blank", {led1, led2, led3}, 0);
      step;
    end else begin
      decode(m);
      step;
      check_digits;
    end
    check("pending", sb.size(), 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (round_ok || round_fail) begin
      if (sb.size() == 0) check("sb_extra", {round_ok, round_fail}, 0);
      else begin
        e = sb.pop_front();
        check("verdict", {round_ok, round_fail}, e.ok ? 2'b10 : 2'b01);
        check("verdict_cyc", cyc, e.cyc);
        check("score", {score_tens_led, score_ones_led}, {seg(e.score / 10), seg(e.score % 10)});
        check("lives", lives, e.lv);
        check("game_over", game_over, e.over);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_nums", {num1, num2, num3}, 0);
    check("rst_leds", {led1, led2, led3}, 0);
    check("rst_score", {score_tens_led, score_ones_led}, {7'b1111110, 7'b1111110});
    check("rst_lives", lives, 3);
    check("rst_flags", {round_ok, round_fail, game_over}, 0);
    reset = 1'b0;
    tick = 1'b1; step; tick = 1'b0; step;
    check("idle_tick", {led1, led2, led3, lives}, {21'd0, 3'd3});
    hunt(3, 12'h460);
    start_game;
    check("p460", {num1, num2, num3}, 12'h460);
    round(3'b001, 0);
    start = 1'b1; step; step; start = 1'b0;
    repeat (4) step;
    check_digits;
    check("ask_start", sb.size(), 0);
    hunt(4, 12'h224);
    round(3'(1 << cop), 0);
    check("p224", {num1, num2, num3}, 12'h224);
    round(3'b100, 0);
    round(3'b011, 0);
    round(3'b000, 1);
    round(3'b000, 1);
    tick = 1'b1; step; tick = 1'b0; step;
    check("over_tick", {game_over, led1, led2, led3}, {1'b1, 21'd0});
    start_game;
    round(3'(1 << cop), 0);
    repeat (3) round(3'b000, 1);
    check("held_score", {score_tens_led, score_ones_led}, {seg(0), seg(1)});
    start_game;
    repeat (100) round(3'(1 << cop), 0);
    check("sat_score", {score_tens_led, score_ones_led}, {seg(9), seg(9)});
    step;
    #2;
    reset = 1'b1;
    #1;
    check("mid_nums", {num1, num2, num3}, 0);
    check("mid_leds", {led1, led2, led3}, 0);
    check("mid_score", {score_tens_led, score_ones_led}, {seg(0), seg(0)});
    check("mid_lives", lives, 3);
    check("mid_flags", {round_ok, round_fail, game_over}, 0);
    step;
    reset = 1'b0;
    step;
    step;
    check("post_idle", {led1, led2, led3}, 0);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
